// File: rtl/mem_master_pkg.sv
// Shared types and constants for the mem_master request/response bridge.
// RW_BASE marks the first writable memory location (used when MEM_MASTER_WRPROT_EN is set).
package mem_master_pkg;

  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned DATA_W_DEF = 8;

  localparam logic [4:0] RW_BASE = 5'h1A;

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StRd,
    StRdCap,
    StWr
  } state_e;

endpackage

// File: rtl/mem_master.sv
// Single-outstanding core-to-memory bridge: one read or write per request, one-cycle response pulse.
// Optional write protection below RW_BASE is enabled by defining MEM_MASTER_WRPROT_EN.
module mem_master
  import mem_master_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              READ,
  output logic              WRITE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_DATA1,
  input  logic [DATA_W-1:0] MEM_DATA2
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                wr_prot;

`ifdef MEM_MASTER_WRPROT_EN
  assign wr_prot = (addr_q < ADDR_W'(RW_BASE));
`else
  assign wr_prot = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StInit;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      StInit: state_d = StIdle;
      StIdle: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = req_we ? StWr : StRd;
        end
      end
      StRd: state_d = StRdCap;
      StRdCap: begin
        // Memory registered the read data on the edge that ended StRd.
        rsp_valid_d = 1'b1;
        rsp_rdata_d = MEM_DATA2;
        rsp_err_d   = 1'b0;
        state_d     = StIdle;
      end
      StWr: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = '0;
        rsp_err_d   = wr_prot;
        state_d     = StIdle;
      end
      default: state_d = StInit;
    endcase
  end

  // Strobes decode straight from the state register so reset clears them asynchronously.
  assign req_ready = (state_q == StIdle);
  assign READ      = (state_q == StRd);
  assign WRITE     = (state_q == StWr) && !wr_prot;
  assign MEM_DATA1 = (state_q == StWr) ? wdata_q : '0;
  assign MEM_ADDR  = addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_master.sv
// Scoreboard bench for mem_master: a transaction-level model predicts strobes and responses
// at acceptance time; independent monitors compare them when the DUT presents them.
module tb_mem_master;

`ifdef MEM_MASTER_WRPROT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif
  localparam int FIRST_RW = 26;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_we = 1'b0;
  logic [4:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       READ, WRITE;
  logic [4:0] MEM_ADDR;
  logic [7:0] MEM_DATA1;
  logic [7:0] MEM_DATA2;

  mem_master dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .READ      (READ),
    .WRITE     (WRITE),
    .MEM_ADDR  (MEM_ADDR),
    .MEM_DATA1 (MEM_DATA1),
    .MEM_DATA2 (MEM_DATA2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Memory: ROM below FIRST_RW, RAM above; read data registered one clock after READ.
  logic [7:0] mem [32];
  logic [7:0] ref_mem [32];
  logic [7:0] rd_q = '0;
  assign MEM_DATA2 = rd_q;
  always @(posedge clk) begin
    if (WRITE && int'(MEM_ADDR) >= FIRST_RW) mem[MEM_ADDR] <= MEM_DATA1;
    if (READ) rd_q <= mem[MEM_ADDR];
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic       we;
    logic [4:0] addr;
    logic [7:0] data;
    int         due;
  } strb_t;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    int         due;
  } rsp_t;

  strb_t strb_q[$];
  rsp_t  rsp_q[$];

  // Transaction model: busy windows, acceptance, predicted strobes/responses.
  int next_rdy = 0;
  bit in_rst = 1'b1;
  int acc_cnt = 0;
  always @(negedge clk) begin
    bit    exp_rdy;
    bit    prot;
    strb_t s;
    rsp_t  r;
    if (!reset_n) begin
      in_rst = 1'b1;
      strb_q.delete();
      rsp_q.delete();
      chk("req_ready_in_reset", req_ready, 0);
    end else begin
      exp_rdy = !in_rst && (cyc >= next_rdy);
      if (in_rst) begin
        in_rst   = 1'b0;
        next_rdy = cyc + 1;
      end
      chk("req_ready", req_ready, exp_rdy);
      if (exp_rdy && req_valid) begin
        acc_cnt++;
        if (req_we) begin
          prot = PROT && (int'(req_addr) < FIRST_RW);
          if (!prot) begin
            s = '{we: 1'b1, addr: req_addr, data: req_wdata, due: cyc + 1};
            strb_q.push_back(s);
            if (int'(req_addr) >= FIRST_RW) ref_mem[req_addr] = req_wdata;
          end
          r = '{rdata: 8'h00, err: prot, due: cyc + 2};
          next_rdy = cyc + 2;
        end else begin
          s = '{we: 1'b0, addr: req_addr, data: 8'h00, due: cyc + 1};
          strb_q.push_back(s);
          r = '{rdata: ref_mem[req_addr], err: 1'b0, due: cyc + 3};
          next_rdy = cyc + 3;
        end
        rsp_q.push_back(r);
      end
    end
  end

  // Monitor: compares whatever the DUT presents against the queued predictions.
  always @(negedge clk) begin
    strb_t s;
    rsp_t  r;
    if (reset_n) begin
      chk("rd_wr_overlap", READ & WRITE, 0);
      if (READ) chk("mem_data1_during_read", MEM_DATA1, 0);
      if (!PROT && !WRITE) chk("mem_data1_idle", MEM_DATA1, 0);
      if (READ || WRITE) begin
        if (strb_q.size() == 0) chk("strobe_unexpected", READ | WRITE, 0);
        else begin
          s = strb_q.pop_front();
          chk("strobe_kind_write", WRITE, s.we);
          chk("strobe_cycle", cyc, s.due);
          chk("mem_addr", MEM_ADDR, s.addr);
          if (s.we) chk("mem_data1", MEM_DATA1, s.data);
        end
      end else if (strb_q.size() != 0 && strb_q[0].due < cyc) begin
        s = strb_q.pop_front();
        chk("strobe_missing_cycle", cyc, s.due);
      end
      if (rsp_valid) begin
        if (rsp_q.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
        else begin
          r = rsp_q.pop_front();
          chk("rsp_cycle", cyc, r.due);
          chk("rsp_rdata", rsp_rdata, r.rdata);
          chk("rsp_err", rsp_err, r.err);
        end
      end else if (rsp_q.size() != 0 && rsp_q[0].due < cyc) begin
        r = rsp_q.pop_front();
        chk("rsp_missing_cycle", cyc, r.due);
      end
    end
  end

  task automatic do_req(input logic we, input logic [4:0] a, input logic [7:0] d);
    int start;
    bit got;
    start     = acc_cnt;
    got       = 1'b0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk);
      if (acc_cnt != start) got = 1'b1;
    end
    if (!got) chk("accept_timeout", acc_cnt - start, 1);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_read", READ, 0);
    chk("rst_write", WRITE, 0);
    chk("rst_mem_addr", MEM_ADDR, 0);
    chk("rst_mem_data1", MEM_DATA1, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'((i * 37 + 11) & 255);
    mem[5'h00] = 8'hBF;
    mem[5'h01] = 8'h5E;
    mem[5'h02] = 8'hDA;
    mem[5'h03] = 8'hBF;
    mem[5'h05] = 8'hBA;
    mem[5'h0D] = 8'h00;
    mem[5'h1C] = 8'h0A;
    mem[5'h1F] = 8'h01;
    for (int i = 0; i < 32; i++) ref_mem[i] = mem[i];

    // Read of 0x00 held across reset release: INIT cycle first, accept next cycle.
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 5'h00;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs();
    reset_n = 1'b1;
    do_req(1'b0, 5'h00, 8'h00);

    do_req(1'b0, 5'h1C, 8'h00);
    do_req(1'b0, 5'h1F, 8'h00);
    do_req(1'b0, 5'h0D, 8'h00);

    do_req(1'b1, 5'h1D, 8'h55);
    do_req(1'b0, 5'h1D, 8'h00);

    do_req(1'b1, 5'h05, 8'hAA);
    do_req(1'b0, 5'h05, 8'h00);

    // Back-to-back reads: valid never drops between requests.
    for (int i = 0; i < 4; i++) do_req(1'b0, 5'(i), 8'h00);

    // Reset during RD: READ must drop asynchronously and the response is lost.
    do_req(1'b0, 5'h03, 8'h00);
    chk("read_in_rd", READ, 1);
    #1;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    do_req(1'b0, 5'h1C, 8'h00);

    for (int n = 0; n < 200; n++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      if (gap > 1) begin
        repeat (gap - 1) @(posedge clk);
        #1;
      end
      do_req(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)));
    end

    repeat (10) @(posedge clk);
    #1;
    chk("strobe_queue_drained", strb_q.size(), 0);
    chk("rsp_queue_drained", rsp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_master.md
MEM_MASTER -- requirements
Module: mem_master

Interface
REQ-001 Parameter ADDR_W, default 5, memory address width.
REQ-002 Parameter DATA_W, default 8, memory data width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  input  1  core request present.
REQ-006 req_ready  output  1  block can accept a request this cycle.
REQ-007 req_we  input  1  1 = write, 0 = read.
REQ-008 req_addr  input  ADDR_W  request address.
REQ-009 req_wdata  input  DATA_W  write data.
REQ-010 rsp_valid  output  1  one-cycle response pulse.
REQ-011 rsp_rdata  output  DATA_W  read data, valid while rsp_valid is high.
REQ-012 rsp_err  output  1  write rejected; valid while rsp_valid is high.
REQ-013 READ  output  1  memory read strobe.
REQ-014 WRITE  output  1  memory write strobe.
REQ-015 MEM_ADDR  output  ADDR_W  memory address.
REQ-016 MEM_DATA1  output  DATA_W  memory write data.
REQ-017 MEM_DATA2  input  DATA_W  memory read data; registered by the memory one clock after READ.

Function
REQ-018 The FSM SHALL use the states INIT, IDLE, RD, RD_CAP and WR.
- INIT lasts exactly one cycle after reset release, then goes to IDLE.
- INIT covers the cycle in which the memory loads its data registers.
REQ-019 req_ready SHALL be 1 only in IDLE.
- A request is accepted when req_valid and req_ready are both 1 at a clock edge.
- On acceptance, we, addr and wdata are latched.
- On acceptance, the FSM goes to RD (we=0) or WR (we=1).
REQ-020 In RD, READ SHALL be 1 for exactly one cycle, then the FSM goes to RD_CAP.
REQ-021 In RD_CAP, MEM_DATA2 SHALL be registered into rsp_rdata and rsp_valid set, then the FSM goes to IDLE.
- Read accepted in cycle T: READ is high in T+1, rsp_valid is high in T+3.
REQ-022 In WR, WRITE SHALL be 1 for exactly one cycle and MEM_DATA1 SHALL equal the latched wdata.
- rsp_valid is high in T+2 with rsp_rdata=0.
REQ-023 READ and WRITE SHALL never be 1 in the same cycle.
- MEM_DATA1 is 0 outside WR.
REQ-024 MEM_ADDR SHALL be driven from the latched address register and hold its value between requests.
REQ-025 rsp_valid SHALL be a single-cycle pulse; it has no backpressure.
REQ-026 A new request SHALL be acceptable in the same cycle that rsp_valid is high.
- Minimum accept spacing: 3 cycles for reads, 2 cycles for writes.
REQ-027 req_* inputs arriving while req_ready=0 SHALL be ignored; no queuing.

Reset
REQ-028 While reset_n=0, the outputs SHALL be:
- state = INIT.
- req_ready, rsp_valid, rsp_err, READ and WRITE all 0.
- MEM_ADDR, MEM_DATA1 and rsp_rdata all 0.
REQ-029 Reset asserted mid-transaction SHALL drop the request with no response, and strobes SHALL clear immediately (asynchronously).

Configuration
REQ-030 With macro MEM_MASTER_WRPROT_EN defined, a write to an address below RW_BASE SHALL NOT assert WRITE.
- The FSM passes through WR with strobes low.
- rsp_err=1 is returned with the T+2 response.
REQ-031 Without MEM_MASTER_WRPROT_EN, every write SHALL assert WRITE and rsp_err SHALL be tied to 0.

Structure
REQ-032 Package mem_master_pkg SHALL hold:
- the state enum;
- ADDR_W and DATA_W defaults;
- RW_BASE = 5'h1A (first writable data location).
REQ-033 No sub-module SHALL be used; the FSM and the request/response registers are flat in mem_master.

Verification
REQ-034 Reset release with req_valid=1, read addr 0x00 held -> req_ready=0 in the INIT cycle, request accepted the next cycle, rsp_valid 3 cycles after accept, rsp_rdata=0xBF.
REQ-035 Read 0x1C after reset -> rsp_rdata=0x0A; read 0x1F -> 0x01; read 0x0D -> 0x00.
REQ-036 Write 0x1D<-0x55 then read 0x1D -> WRITE high one cycle with MEM_DATA1=0x55, write ack at T+2, read returns 0x55.
REQ-037 Write 0x05<-0xAA:
- with MEM_MASTER_WRPROT_EN -> WRITE never high, rsp_err=1;
- without it -> WRITE high one cycle, rsp_err=0;
- a subsequent read of 0x05 returns 0xBA in both builds.
REQ-038 reset_n pulled low during RD -> READ falls in the same cycle, no rsp_valid follows, and the FSM re-enters INIT then IDLE.
REQ-039 Continuous req_valid with reads to 0x00..0x03 -> accepts every 3 cycles, responses 0xBF, 0x5E, 0xDA, 0xBF in order, READ/WRITE never overlap.
